// File: rtl/repack_pkg.sv
// Shared definitions for the packet-aware lane repacker.
//   cnt_w(n) : bits needed to hold a count in 0..n
//   lane_t   : one lane at the default lane width LANE_W
package repack_pkg;

    localparam int unsigned LANE_W = 8;

    typedef logic [LANE_W-1:0] lane_t;

    function automatic int unsigned cnt_w(input int unsigned n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/repack_lane_mux.sv
// Next-state lane selector for the repacker buffer.
// Ports:
//   mem_i  : current buffer lanes, index 0 is the head
//   v_i    : current fill count in lanes
//   pop_i  : head beat is consumed this cycle
//   pc_i   : lanes removed from the head on pop
//   push_i : input beat is accepted this cycle
//   data_i : input lanes, lane 0 in the low bits
//   cnt_i  : valid input lanes
//   mem_o  : buffer lanes for the next cycle, lanes at or above the new fill are 0
module repack_lane_mux
    import repack_pkg::*;
#(
    parameter int unsigned IN   = 3,
    parameter int unsigned BUFF = 24,
    parameter int unsigned W    = LANE_W
) (
    input  logic [W-1:0]           mem_i [BUFF],
    input  logic [cnt_w(BUFF)-1:0] v_i,
    input  logic                   pop_i,
    input  logic [cnt_w(BUFF)-1:0] pc_i,
    input  logic                   push_i,
    input  logic [W*IN-1:0]        data_i,
    input  logic [cnt_w(IN)-1:0]   cnt_i,
    output logic [W-1:0]           mem_o [BUFF]
);

    localparam int unsigned VW  = cnt_w(BUFF);
    localparam int unsigned IW  = (BUFF > 1) ? $clog2(BUFF) : 1;
    localparam int unsigned LIW = (IN > 1) ? $clog2(IN) : 1;

    logic [W-1:0]  in_lane [IN];
    logic [VW-1:0] shift;
    logic [VW-1:0] base;

    // Split the input bus into lanes with constant selects.
    for (genvar g = 0; g < IN; g++) begin : g_in_lane
        assign in_lane[g] = data_i[g*W +: W];
    end

    // Shift survivors down by the popped count, then append the pushed lanes.
    always_comb begin
        shift = pop_i ? pc_i : '0;
        base  = v_i - shift;
        for (int unsigned i = 0; i < BUFF; i++) begin
            mem_o[IW'(i)] = '0;
            if ((i < 32'(base)) && (i + 32'(shift) < BUFF)) begin
                mem_o[IW'(i)] = mem_i[IW'(i + 32'(shift))];
            end
        end
        for (int unsigned j = 0; j < IN; j++) begin
            if (push_i && (j < 32'(cnt_i)) && (32'(base) + j < BUFF)) begin
                mem_o[IW'(32'(base) + j)] = in_lane[LIW'(j)];
            end
        end
    end

endmodule

// File: rtl/repacker_pkt.sv
// Packet-aware lane repacker: takes beats of 0..IN lanes, emits OUT-lane beats,
// with a partial, last-flagged tail beat per packet. Packets never merge.
// Optional feature macro: REPACKER_PKT_STATS_EN adds level_o, pkt_cnt_o, lane_cnt_o.
// Ports:
//   clk_i, rst_ni (async, active-low), srst_i (sync clear, beats push/pop)
//   in_val_i/in_rdy_o, in_data_i, in_cnt_i, in_last_i : input beat
//   out_val_o/out_rdy_i, out_data_o, out_cnt_o, out_last_o : output beat
//   level_o, pkt_cnt_o, lane_cnt_o : fill level and popped packet/lane totals
module repacker_pkt
    import repack_pkg::*;
#(
    parameter int unsigned IN   = 3,
    parameter int unsigned OUT  = 8,
    parameter int unsigned BUFF = 24,
    parameter int unsigned W    = LANE_W
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   srst_i,
    input  logic                   in_val_i,
    input  logic [W*IN-1:0]        in_data_i,
    input  logic [cnt_w(IN)-1:0]   in_cnt_i,
    input  logic                   in_last_i,
    output logic                   in_rdy_o,
    output logic                   out_val_o,
    output logic [W*OUT-1:0]       out_data_o,
    output logic [cnt_w(OUT)-1:0]  out_cnt_o,
    output logic                   out_last_o,
    input  logic                   out_rdy_i
`ifdef REPACKER_PKT_STATS_EN
    ,
    output logic [cnt_w(BUFF)-1:0] level_o,
    output logic [31:0]            pkt_cnt_o,
    output logic [31:0]            lane_cnt_o
`endif
);

    localparam int unsigned VW = cnt_w(BUFF);
    localparam int unsigned OW = cnt_w(OUT);

    if (BUFF < IN + OUT - 1) begin : g_buff_check
        $error("repacker_pkt: BUFF must be >= IN+OUT-1");
    end

    logic [W-1:0]  mem_q   [BUFF];
    logic [W-1:0]  mem_d   [BUFF];
    logic [W-1:0]  mem_nxt [BUFF];
    logic [VW-1:0] v_q, v_d;
    logic          lp_q, lp_d;
    logic          push, pop;
    logic [OW-1:0] pc;

    // Handshake and beat framing, all from registered state.
    assign in_rdy_o   = !lp_q && (32'(v_q) + IN <= BUFF);
    assign out_val_o  = (32'(v_q) >= OUT) || lp_q;
    assign out_last_o = lp_q && (32'(v_q) <= OUT);
    assign pc         = out_last_o ? OW'(v_q) : OW'(OUT);
    assign push       = in_val_i && in_rdy_o;
    assign pop        = out_val_o && out_rdy_i;

    // Count and data read as zero while no beat is offered (matches reset view).
    assign out_cnt_o  = out_val_o ? pc : '0;
    for (genvar k = 0; k < OUT; k++) begin : g_out_lane
        assign out_data_o[k*W +: W] = (out_val_o && (32'(pc) > 32'(k))) ? mem_q[k] : '0;
    end

    repack_lane_mux #(
        .IN   (IN),
        .BUFF (BUFF),
        .W    (W)
    ) u_lane_mux (
        .mem_i  (mem_q),
        .v_i    (v_q),
        .pop_i  (pop),
        .pc_i   (VW'(pc)),
        .push_i (push),
        .data_i (in_data_i),
        .cnt_i  (in_cnt_i),
        .mem_o  (mem_nxt)
    );

    // Fill count and last-pending update; srst_i wins over any push/pop.
    always_comb begin
        mem_d = mem_nxt;
        v_d   = v_q;
        lp_d  = lp_q;
        if (push) v_d = v_d + VW'(in_cnt_i);
        if (pop)  v_d = v_d - VW'(pc);
        if (pop && out_last_o) lp_d = 1'b0;
        if (push && in_last_i) lp_d = 1'b1;
        if (srst_i) begin
            mem_d = '{default: '0};
            v_d   = '0;
            lp_d  = 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            mem_q <= '{default: '0};
            v_q   <= '0;
            lp_q  <= 1'b0;
        end else begin
            mem_q <= mem_d;
            v_q   <= v_d;
            lp_q  <= lp_d;
        end
    end

`ifdef REPACKER_PKT_STATS_EN
    logic [31:0] pkt_cnt_q, pkt_cnt_d;
    logic [31:0] lane_cnt_q, lane_cnt_d;

    // Popped packet and lane totals, wrapping.
    always_comb begin
        pkt_cnt_d  = pkt_cnt_q;
        lane_cnt_d = lane_cnt_q;
        if (pop) begin
            lane_cnt_d = lane_cnt_q + 32'(pc);
            if (out_last_o) pkt_cnt_d = pkt_cnt_q + 32'd1;
        end
        if (srst_i) begin
            pkt_cnt_d  = '0;
            lane_cnt_d = '0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            pkt_cnt_q  <= '0;
            lane_cnt_q <= '0;
        end else begin
            pkt_cnt_q  <= pkt_cnt_d;
            lane_cnt_q <= lane_cnt_d;
        end
    end

    assign level_o    = v_q;
    assign pkt_cnt_o  = pkt_cnt_q;
    assign lane_cnt_o = lane_cnt_q;
`endif

    a_in_cnt_legal: assert property (@(posedge clk_i) disable iff (!rst_ni)
        in_val_i |-> ((32'(in_cnt_i) <= IN) && ((in_cnt_i != '0) || in_last_i)));

    // A stalled beat holds; last may only rise when the packet end arrives for a full beat.
    a_out_hold: assert property (@(posedge clk_i) disable iff (!rst_ni)
        (out_val_o && !out_rdy_i && !srst_i) |=>
        (out_val_o && $stable(out_data_o) && $stable(out_cnt_o) && (out_last_o || !$past(out_last_o))));

endmodule
